// File: rtl/serial_addsub.sv
// -----------------------------------------------------------------------------
// serial_addsub
// Multi-cycle adder/subtractor. The WIDTH-bit operands are processed DIGIT bits
// per clock, least significant digit first. The carry (add) or borrow (sub)
// ripples from one digit to the next through a register.
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   operands/mode valid (only sampled in IDLE)
//   in_ready   block can accept operands (1 only in IDLE)
//   a, b       operands (minuend/subtrahend or addends)
//   sub        1 = subtract, 0 = add
//   cbin       carry-in (add) or borrow-in (sub)
//   out_valid  result valid (1 only in DONE)
//   out_ready  consumer accepts result
//   result     sum or difference, modulo 2^WIDTH
//   cbout      carry-out (add) or borrow-out (sub)
//   overflow   two's-complement signed overflow
//
// All outputs come straight from registers.
// -----------------------------------------------------------------------------
module serial_addsub #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cbin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cbout,
    output logic             overflow
);

    // Reject illegal parameter combinations at elaboration time.
    if ((WIDTH < 1) || (DIGIT < 1) || (DIGIT > WIDTH) || ((WIDTH % DIGIT) != 0)) begin : g_bad_params
        $error("serial_addsub: illegal WIDTH/DIGIT combination");
    end

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST_DIGIT = CW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [CW-1:0]      r_cnt;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_sub;
    logic               r_cb;
    logic [WIDTH-1:0]   r_result;
    logic               r_cbout;
    logic               r_ovf;
    logic               r_in_ready;
    logic               r_out_valid;

    logic [DIGIT-1:0]   w_a_dig;
    logic [DIGIT-1:0]   w_b_dig;
    logic [DIGIT-1:0]   w_dig;
    logic               w_cout;
    logic               w_ovf;
    logic               w_last;

    assign w_last = (r_cnt == LAST_DIGIT);

    // Select the operand digit addressed by the digit counter.
    always_comb begin
        w_a_dig = {DIGIT{1'b0}};
        w_b_dig = {DIGIT{1'b0}};
        for (int k = 0; k < N; k++) begin
            w_a_dig = (r_cnt == CW'(k)) ? r_a[k*DIGIT +: DIGIT] : w_a_dig;
            w_b_dig = (r_cnt == CW'(k)) ? r_b[k*DIGIT +: DIGIT] : w_b_dig;
        end
    end

    // Ripple DIGIT full-adder / full-subtractor cells starting from the
    // registered carry/borrow; the sum/difference bit is the same XOR either way.
    always_comb begin
        logic w_c;
        w_c   = r_cb;
        w_dig = {DIGIT{1'b0}};
        for (int i = 0; i < DIGIT; i++) begin
            w_dig[i] = w_a_dig[i] ^ w_b_dig[i] ^ w_c;
            if (r_sub) begin
                w_c = (~w_a_dig[i] & (w_b_dig[i] ^ w_c)) | (w_b_dig[i] & w_c);
            end else begin
                w_c = (w_a_dig[i] & w_b_dig[i]) | (w_c & (w_a_dig[i] ^ w_b_dig[i]));
            end
        end
        w_cout = w_c;
    end

    // Signed overflow; only meaningful on the last digit, where w_dig's top
    // bit is the result MSB.
    always_comb begin
        if (r_sub) begin
            w_ovf = (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_dig[DIGIT-1] != r_a[WIDTH-1]);
        end else begin
            w_ovf = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_dig[DIGIT-1] != r_a[WIDTH-1]);
        end
    end

    // Next-state logic for the IDLE -> RUN -> DONE handshake sequence.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  w_state_next = in_valid  ? S_RUN  : S_IDLE;
            S_RUN:   w_state_next = w_last    ? S_DONE : S_RUN;
            S_DONE:  w_state_next = out_ready ? S_IDLE : S_DONE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // State register plus registered handshake flags derived from next state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_in_ready  <= (w_state_next == S_IDLE);
            r_out_valid <= (w_state_next == S_DONE);
        end
    end

    // Datapath: operand capture, digit write-back, carry ripple and flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt    <= {CW{1'b0}};
            r_a      <= {WIDTH{1'b0}};
            r_b      <= {WIDTH{1'b0}};
            r_sub    <= 1'b0;
            r_cb     <= 1'b0;
            r_result <= {WIDTH{1'b0}};
            r_cbout  <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a   <= a;
                        r_b   <= b;
                        r_sub <= sub;
                        r_cb  <= cbin;
                        r_cnt <= {CW{1'b0}};
                    end
                end
                S_RUN: begin
                    for (int k = 0; k < N; k++) begin
                        if (r_cnt == CW'(k)) begin
                            r_result[k*DIGIT +: DIGIT] <= w_dig;
                        end
                    end
                    r_cb <= w_cout;
                    if (w_last) begin
                        r_cnt   <= {CW{1'b0}};
                        r_cbout <= w_cout;
                        r_ovf   <= w_ovf;
                    end else begin
                        r_cnt   <= r_cnt + CW'(1);
                    end
                end
                default: begin
                    // DONE holds everything stable until the consumer takes it.
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign cbout     = r_cbout;
    assign overflow  = r_ovf;

endmodule

// File: tb/tb_serial_addsub.sv
// -----------------------------------------------------------------------------
// tb_serial_addsub
// Self-checking bench for serial_addsub. Three instances cover WIDTH=8/DIGIT=2,
// WIDTH=1/DIGIT=1 and WIDTH=32/DIGIT=4. Directed tables, hand-written
// backpressure and reset sequences, and random operations checked against an
// arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_serial_addsub;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    // Instance 0: WIDTH=8, DIGIT=2
    logic iv0 = 1'b0, ir0, s0 = 1'b0, c0 = 1'b0, ov0, or0 = 1'b0, cb0, of0;
    logic [7:0] a0 = 8'h00, b0 = 8'h00, r0;
    // Instance 1: WIDTH=1, DIGIT=1
    logic iv1 = 1'b0, ir1, s1 = 1'b0, c1 = 1'b0, ov1, or1 = 1'b0, cb1, of1;
    logic [0:0] a1 = 1'b0, b1 = 1'b0, r1;
    // Instance 2: WIDTH=32, DIGIT=4
    logic iv2 = 1'b0, ir2, s2 = 1'b0, c2 = 1'b0, ov2, or2 = 1'b0, cb2, of2;
    logic [31:0] a2 = 32'h0, b2 = 32'h0, r2;

    serial_addsub #(.WIDTH(8), .DIGIT(2)) u_w8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0), .a(a0), .b(b0),
        .sub(s0), .cbin(c0), .out_valid(ov0), .out_ready(or0), .result(r0),
        .cbout(cb0), .overflow(of0));

    serial_addsub #(.WIDTH(1), .DIGIT(1)) u_w1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1),
        .sub(s1), .cbin(c1), .out_valid(ov1), .out_ready(or1), .result(r1),
        .cbout(cb1), .overflow(of1));

    serial_addsub #(.WIDTH(32), .DIGIT(4)) u_w32 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2), .a(a2), .b(b2),
        .sub(s2), .cbin(c2), .out_valid(ov2), .out_ready(or2), .result(r2),
        .cbout(cb2), .overflow(of2));

    typedef struct {
        logic        s;
        logic [31:0] a;
        logic [31:0] b;
        logic        c;
        logic [31:0] r;
        logic        cb;
        logic        ov;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on WIDTH-bit values.
    function automatic logic [33:0] model(input int w, input logic [31:0] a, input logic [31:0] b,
                                          input logic s, input logic c);
        logic [63:0] mask, aa, bb, full, res;
        logic cb, am, bm, rm, ov;
        mask = (64'd1 << w) - 64'd1;
        aa = {32'd0, a} & mask;
        bb = {32'd0, b} & mask;
        if (!s) begin
            full = aa + bb + {63'd0, c};
            cb   = full[w];
        end else begin
            full = aa - bb - {63'd0, c};
            cb   = (aa < (bb + {63'd0, c}));
        end
        res = full & mask;
        am = aa[w-1];
        bm = bb[w-1];
        rm = res[w-1];
        ov = s ? ((am != bm) && (rm != am)) : ((am == bm) && (rm != am));
        return {ov, cb, res[31:0]};
    endfunction

    function automatic logic get_ov(input int cfg);
        case (cfg)
            0: return ov0;
            1: return ov1;
            default: return ov2;
        endcase
    endfunction

    function automatic logic get_ir(input int cfg);
        case (cfg)
            0: return ir0;
            1: return ir1;
            default: return ir2;
        endcase
    endfunction

    function automatic logic [33:0] get_out(input int cfg);
        case (cfg)
            0: return {of0, cb0, 24'd0, r0};
            1: return {of1, cb1, 31'd0, r1};
            default: return {of2, cb2, r2};
        endcase
    endfunction

    task automatic set_in(input int cfg, input logic v, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input logic c);
        case (cfg)
            0: begin iv0 = v; a0 = a[7:0]; b0 = b[7:0]; s0 = s; c0 = c; end
            1: begin iv1 = v; a1 = a[0:0]; b1 = b[0:0]; s1 = s; c1 = c; end
            default: begin iv2 = v; a2 = a; b2 = b; s2 = s; c2 = c; end
        endcase
    endtask

    task automatic set_or(input int cfg, input logic v);
        case (cfg)
            0: or0 = v;
            1: or1 = v;
            default: or2 = v;
        endcase
    endtask

    // One operation: present operands, scramble them after acceptance, wait
    // (bounded) for out_valid, capture outputs, optionally release DONE.
    task automatic do_op(input int cfg, input logic [31:0] a, input logic [31:0] b,
                         input logic s, input logic c, input bit rel,
                         output logic [33:0] got, output int lat);
        @(negedge clk);
        set_in(cfg, 1'b1, a, b, s, c);
        @(posedge clk);
        #1;
        set_in(cfg, 1'b0, $urandom, $urandom, 1'($urandom), 1'($urandom));
        lat = 0;
        while (!get_ov(cfg) && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
        got = get_out(cfg);
        if (rel) begin
            @(negedge clk);
            set_or(cfg, 1'b1);
            @(posedge clk);
            #1;
            set_or(cfg, 1'b0);
        end
    endtask

    initial begin
        vec_t tab8[8];
        vec_t tab1[8];
        logic [33:0] got, exp;
        int lat;
        int seen;
        logic [31:0] ra, rb;
        logic rs, rc;

        tab8[0] = '{1'b1, 32'h05, 32'h03, 1'b0, 32'h02, 1'b0, 1'b0};
        tab8[1] = '{1'b1, 32'h00, 32'h01, 1'b1, 32'hFE, 1'b1, 1'b0};
        tab8[2] = '{1'b1, 32'h80, 32'h01, 1'b0, 32'h7F, 1'b0, 1'b1};
        tab8[3] = '{1'b0, 32'h7F, 32'h01, 1'b0, 32'h80, 1'b0, 1'b1};
        tab8[4] = '{1'b0, 32'hFF, 32'h01, 1'b1, 32'h01, 1'b1, 1'b0};
        tab8[5] = '{1'b0, 32'h80, 32'h80, 1'b0, 32'h00, 1'b1, 1'b1};
        tab8[6] = '{1'b1, 32'h7F, 32'hFF, 1'b0, 32'h80, 1'b1, 1'b1};
        tab8[7] = '{1'b0, 32'h00, 32'h00, 1'b1, 32'h01, 1'b0, 1'b0};

        // 1-bit full subtractor truth table {a,b,bin} -> diff, bout, overflow
        tab1[0] = '{1'b1, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0};
        tab1[1] = '{1'b1, 32'd0, 32'd0, 1'b1, 32'd1, 1'b1, 1'b0};
        tab1[2] = '{1'b1, 32'd0, 32'd1, 1'b0, 32'd1, 1'b1, 1'b1};
        tab1[3] = '{1'b1, 32'd0, 32'd1, 1'b1, 32'd0, 1'b1, 1'b0};
        tab1[4] = '{1'b1, 32'd1, 32'd0, 1'b0, 32'd1, 1'b0, 1'b0};
        tab1[5] = '{1'b1, 32'd1, 32'd0, 1'b1, 32'd0, 1'b0, 1'b1};
        tab1[6] = '{1'b1, 32'd1, 32'd1, 1'b0, 32'd0, 1'b0, 1'b0};
        tab1[7] = '{1'b1, 32'd1, 32'd1, 1'b1, 32'd1, 1'b1, 1'b0};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        for (int c = 0; c < 3; c++) begin
            chk("rst_in_ready", 64'(get_ir(c)), 64'd1);
            chk("rst_out_valid", 64'(get_ov(c)), 64'd0);
            chk("rst_outputs", 64'(get_out(c)), 64'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Directed WIDTH=8 vectors
        for (int i = 0; i < 8; i++) begin
            do_op(0, tab8[i].a, tab8[i].b, tab8[i].s, tab8[i].c, 1'b1, got, lat);
            chk("w8_result", 64'(got[31:0]), 64'(tab8[i].r));
            chk("w8_cbout", 64'(got[32]), 64'(tab8[i].cb));
            chk("w8_overflow", 64'(got[33]), 64'(tab8[i].ov));
            chk("w8_latency", 64'(lat), 64'd4);
        end

        // WIDTH=1 truth table
        for (int i = 0; i < 8; i++) begin
            do_op(1, tab1[i].a, tab1[i].b, tab1[i].s, tab1[i].c, 1'b1, got, lat);
            chk("w1_result", 64'(got[31:0]), 64'(tab1[i].r));
            chk("w1_bout", 64'(got[32]), 64'(tab1[i].cb));
            chk("w1_overflow", 64'(got[33]), 64'(tab1[i].ov));
            chk("w1_latency", 64'(lat), 64'd1);
        end

        // Backpressure: hold DONE, offer new operands which must be ignored
        do_op(0, 32'h12, 32'h34, 1'b0, 1'b0, 1'b0, got, lat);
        chk("bp_first_result", 64'(got[31:0]), 64'h46);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            set_in(0, 1'b1, $urandom, $urandom, 1'b1, 1'b1);
            @(posedge clk);
            #1;
            chk("bp_hold_result", 64'(get_out(0)), 64'h46);
            chk("bp_in_ready", 64'(ir0), 64'd0);
            chk("bp_out_valid", 64'(ov0), 64'd1);
        end
        @(negedge clk);
        set_in(0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        or0 = 1'b1;
        @(posedge clk);
        #1;
        or0 = 1'b0;
        chk("bp_release_in_ready", 64'(ir0), 64'd1);
        chk("bp_release_out_valid", 64'(ov0), 64'd0);
        @(posedge clk);
        #1;
        chk("bp_no_new_op", 64'(ir0), 64'd1);

        // Reset during the second RUN cycle aborts the operation
        @(negedge clk);
        set_in(0, 1'b1, 32'h11, 32'h22, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        set_in(0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_rst_out_valid", 64'(ov0), 64'd0);
        chk("mid_rst_in_ready", 64'(ir0), 64'd1);
        chk("mid_rst_result", 64'(get_out(0)), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (ov0) seen++;
        end
        chk("mid_rst_no_out_valid", 64'(seen), 64'd0);
        do_op(0, 32'h10, 32'h20, 1'b1, 1'b0, 1'b1, got, lat);
        chk("post_rst_result", 64'(got[31:0]), 64'hF0);
        chk("post_rst_cbout", 64'(got[32]), 64'd1);
        chk("post_rst_overflow", 64'(got[33]), 64'd0);
        chk("post_rst_latency", 64'(lat), 64'd4);

        // Random WIDTH=8 operations
        for (int i = 0; i < 100; i++) begin
            ra = $urandom; rb = $urandom; rs = 1'($urandom); rc = 1'($urandom);
            do_op(0, ra, rb, rs, rc, 1'b1, got, lat);
            exp = model(8, ra, rb, rs, rc);
            chk("rnd8_out", 64'(got), 64'(exp));
            chk("rnd8_latency", 64'(lat), 64'd4);
        end

        // Random WIDTH=32 operations
        for (int i = 0; i < 1000; i++) begin
            ra = $urandom; rb = $urandom; rs = 1'($urandom); rc = 1'($urandom);
            if (i % 10 == 0) ra = {ra[31], 31'h7FFF_FFFF};
            do_op(2, ra, rb, rs, rc, 1'b1, got, lat);
            exp = model(32, ra, rb, rs, rc);
            chk("rnd32_result", 64'(got[31:0]), 64'(exp[31:0]));
            chk("rnd32_cbout", 64'(got[32]), 64'(exp[32]));
            chk("rnd32_overflow", 64'(got[33]), 64'(exp[33]));
            chk("rnd32_latency", 64'(lat), 64'd8);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_addsub.md
Name: serial_addsub

Overview:
Multi-cycle, parametrised adder/subtractor. It processes WIDTH-bit operands DIGIT bits per clock, LSB digit first, and ripples the carry/borrow between digits through a register. It generalises the 1-bit full subtractor into a word-wide add/sub unit with mode select, signed-overflow flag and valid/ready handshakes on input and output. It sits in the combinational_ckt arithmetic library as the area-lean alternative to a full-width ripple unit.

Parameters:
WIDTH, 32, operand/result width in bits; must be >= 1.
DIGIT, 4, bits processed per RUN cycle; 1 <= DIGIT <= WIDTH; WIDTH % DIGIT == 0 (elaboration error otherwise).

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
in_valid  input  1  operands/mode valid
in_ready  output  1  block can accept operands
a  input  WIDTH  minuend / addend
b  input  WIDTH  subtrahend / addend
sub  input  1  1 = subtract, 0 = add
cbin  input  1  carry-in (add) or borrow-in (sub)
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
result  output  WIDTH  sum or difference
cbout  output  1  carry-out (add) or borrow-out (sub)
overflow  output  1  two's-complement signed overflow

Behaviour:
- One clock; reset is synchronous and active-low (clk, rst_n). The polarity and synchronicity are fixed.
- Reset (rst_n=0 at a clk edge): state=IDLE, in_ready=1, out_valid=0, result=0, cbout=0, overflow=0, digit counter=0, internal operand/carry registers=0.
- FSM has three states: IDLE, RUN, DONE. in_ready=1 only in IDLE; out_valid=1 only in DONE.
- IDLE: in_valid=1 at an edge latches a, b, sub and cbin; counter=0; next state RUN. in_valid=0 stays in IDLE.
- RUN: each cycle computes digit k = counter (bits k*DIGIT+DIGIT-1 .. k*DIGIT) from the latched operands and the registered carry/borrow, then writes that digit of result. counter increments each cycle.
- RUN after digit N-1 (N = WIDTH/DIGIT): next state DONE, cbout and overflow are registered.
- DONE: result, cbout and overflow are held stable while out_valid=1 and out_ready=0. out_ready=1 at an edge moves to IDLE.
- Latency: if operands are accepted at edge T, out_valid rises after edge T+N. Minimum initiation interval is N+2 cycles.
- Add: {cbout,result} = a + b + cbin (WIDTH+1 bits, exact).
- Sub: result = (a - b - cbin) mod 2^WIDTH. cbout=1 iff unsigned a < b + cbin. Per bit: diff = a^b^bin, bout = (~a&(b^bin))|(b&bin).
- overflow: add sets it when a[MSB]==b[MSB] and result[MSB]!=a[MSB]. Sub sets it when a[MSB]!=b[MSB] and result[MSB]!=a[MSB].
- in_valid is ignored outside IDLE; operands may change freely then.
- Changes on a/b/sub/cbin after acceptance do not affect the operation in flight.
- Reset mid-RUN or mid-DONE aborts the operation. No out_valid is produced for it, and the state is as after reset.
- WIDTH==DIGIT is legal: a single RUN cycle.
- No combinational path from any input to any output; all outputs are registered.

Test Plan:
1. WIDTH=8, DIGIT=2, sub=1, a=0x05, b=0x03, cbin=0, accepted at edge T -> out_valid after edge T+4; result=0x02, cbout=0, overflow=0.
2. WIDTH=8, DIGIT=2: sub a=0x00, b=0x01, cbin=1 -> result=0xFE, cbout=1, overflow=0. Sub a=0x80, b=0x01, cbin=0 -> result=0x7F, cbout=0, overflow=1.
3. WIDTH=8, DIGIT=2: add a=0x7F, b=0x01, cbin=0 -> result=0x80, cbout=0, overflow=1. Add a=0xFF, b=0x01, cbin=1 -> result=0x01, cbout=1, overflow=0.
4. Backpressure: hold out_ready=0 for 3 cycles in DONE, pulse in_valid with new operands -> result unchanged, in_ready=0, new operands ignored. out_ready=1 -> IDLE next cycle, in_ready=1.
5. Reset: assert rst_n=0 on the 2nd RUN cycle -> next cycle state IDLE, out_valid=0, result=0. Then run a=0x10, b=0x20, sub=1 -> result=0xF0, cbout=1 with normal latency.
6. WIDTH=1, DIGIT=1, sub=1: all 8 {a,b,cbin} combinations (e.g. a=0, b=1, cbin=1 -> result=0, cbout=1). Then WIDTH=32, DIGIT=4 with 1000 random add/sub ops -> every result/cbout/overflow matches the model, each with 8-cycle latency.
